regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
Two-requester arbiter that shares the single register_file instance between requester A (the tiny RISC-V core FSM) and requester B (debug/loader port).
- Each grant runs one transaction: two reads plus an optional write.
- The transaction drives the register file ports from registered outputs, captures the read data, and returns it with a one-cycle valid pulse.
- Arbitration is round-robin with fixed per-transaction latency.
- The block also suppresses writes to x0 and counts contention events.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
PRIO_INIT, 0, requester favoured after reset (0 = A, 1 = B)
CNT_W, 8, width of the saturating contention counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
req_a  input  1  A requests a transaction; fields below held stable while req_a=1 and gnt_a=0
we_a  input  1  A transaction includes a write
rr1_a, rr2_a  input  ADDR_W each  A read indices
wr_a  input  ADDR_W  A write index
wd_a  input  DATA_W  A write data
gnt_a  output  1  one-cycle grant pulse to A
rvalid_a  output  1  one-cycle read-data-valid pulse to A
rdata1_a, rdata2_a  output  DATA_W each  A read results
req_b, we_b, rr1_b, rr2_b, wr_b, wd_b  input  same as A  requester B fields
gnt_b, rvalid_b, rdata1_b, rdata2_b  output  same as A  requester B responses
rf_we  output  1  register file write enable
rf_rr1, rf_rr2, rf_wr  output  ADDR_W each  register file indices
rf_wd  output  DATA_W  register file write data
rf_rd1, rf_rd2  input  DATA_W each  register file read data; combinational from rf_rr1/rf_rr2
busy  output  1  state != IDLE
conflict_cnt  output  CNT_W  saturating count of arbitration decisions with both requests high

Behaviour:
Clock and reset:
- One clock, clk. Reset rst is synchronous and active-low: sampled only on the rising edge of clk.

Reset (rst=0 at a rising edge):
- state=IDLE; prio=PRIO_INIT.
- Every output is 0: gnt_*, rvalid_*, rdata*_*, rf_*, busy, conflict_cnt.
- An in-flight transaction is dropped: no rvalid is produced, and rf_we is 0 from the next cycle.

States:
- IDLE: no transaction.
  - If req_a or req_b is high, pick the winner:
    - only one requesting -> that one;
    - both requesting -> the one selected by prio.
  - At the edge:
    - gnt_<w> <= 1;
    - rf_rr1/rf_rr2/rf_wr/rf_wd <= winner's fields;
    - rf_we <= we_<w> AND (wr_<w> != 0);
    - latch the winner id; prio <= other requester;
    - if both requested, conflict_cnt <= conflict_cnt+1 unless at all-ones (saturates, no wrap);
    - state <= ACCESS.
  - No request -> stay IDLE, all rf_* hold and rf_we=0.
- ACCESS: exactly one cycle. gnt pulse visible and rf_* valid; requests are not sampled.
  - At the edge:
    - rdata1_<w> <= (rf_rr1==0) ? 0 : rf_rd1;
    - rdata2_<w> <= (rf_rr2==0) ? 0 : rf_rd2;
    - rvalid_<w> <= 1;
    - gnt_* <= 0; rf_we <= 0;
    - state <= RESP.
- RESP: rvalid_<w>=1 for this one cycle only. Arbitration is identical to IDLE:
  - a pending request -> grant at this edge, state <= ACCESS;
  - otherwise state <= IDLE.
  - rvalid_* <= 0 at this edge.

Latency and throughput:
- Request sampled in cycle T -> gnt in T+1 (ACCESS) -> rvalid and rdata in T+2.
- Back-to-back maximum rate is one transaction per 2 cycles.

Write and read ordering:
- The write commits at the clock edge ending ACCESS.
- Reads in the same transaction return the pre-write value.
- A following transaction observes the write.

Requester rules:
- The requester deasserts req by the cycle after it sees gnt (T+2).
- If req is still high in RESP, that is a new request.

Hold behaviour:
- rdata*_* hold their last value until the next rvalid for that requester.
- rdata*_* of the non-winner are unchanged.

x0 handling:
- A write with wr=0 performs no write (rf_we stays 0).
- Reads of index 0 return 0 regardless of rf_rd*.

Test Plan:
- Single read: prefill x3=0x11, x4=0x22; req_a with rr1=3, rr2=4, we=0 at cycle T -> gnt_a at T+1, rvalid_a at T+2 with rdata1_a=0x11 and rdata2_a=0x22; rf_we never high.
- Write then read: B writes x7=0xDEADBEEF with rr1=7 -> rvalid_b rdata1_b = old x7. Next B read of x7 -> 0xDEADBEEF.
- Contention: req_a and req_b held high continuously from reset with PRIO_INIT=0 -> grant order A,B,A,B at 2-cycle spacing; conflict_cnt increments each decision.
- x0 guard: A write wr=0, wd=0x5 -> rf_we stays 0. Read rr1=0 with rf_rd1 forced to 0xFFFFFFFF -> rdata1_a=0.
- Reset mid-op: assert rst=0 in the ACCESS cycle of a write -> next cycle all outputs 0, state IDLE, no rvalid, prio=PRIO_INIT.
- Saturation: CNT_W=2, hold both requests for 5 contested grants -> conflict_cnt reaches 3 and holds at 3.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin A/B arbiter driving one register file, one 2-read/1-write transaction per grant
module regfile_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter bit PRIO_INIT = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] rr1_a,
    input  logic [ADDR_W-1:0] rr2_a,
    input  logic [ADDR_W-1:0] wr_a,
    input  logic [DATA_W-1:0] wd_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata1_a,
    output logic [DATA_W-1:0] rdata2_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] rr1_b,
    input  logic [ADDR_W-1:0] rr2_b,
    input  logic [ADDR_W-1:0] wr_b,
    input  logic [DATA_W-1:0] wd_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata1_b,
    output logic [DATA_W-1:0] rdata2_b,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rr1,
    output logic [ADDR_W-1:0] rf_rr2,
    output logic [ADDR_W-1:0] rf_wr,
    output logic [DATA_W-1:0] rf_wd,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic              busy,
    output logic [CNT_W-1:0]  conflict_cnt
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic prio, win, arb, both, pick_b;
    logic [DATA_W-1:0] rd1_m, rd2_m;
    always_ff @(posedge clk) state <= !rst ? IDLE : state_nx;
    always_comb state_nx = state == ACCESS ? RESP : arb ? ACCESS : IDLE;
    always_comb begin
        arb    = state != ACCESS && (req_a || req_b);
        both   = req_a && req_b;
        pick_b = req_b && (!req_a || prio);
        busy   = state != IDLE;
        rd1_m  = rf_rr1 == '0 ? '0 : rf_rd1;
        rd2_m  = rf_rr2 == '0 ? '0 : rf_rd2;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            prio         <= PRIO_INIT;
            win          <= 1'b0;
            gnt_a        <= 1'b0;
            gnt_b        <= 1'b0;
            rvalid_a     <= 1'b0;
            rvalid_b     <= 1'b0;
            rdata1_a     <= '0;
            rdata2_a     <= '0;
            rdata1_b     <= '0;
            rdata2_b     <= '0;
            rf_we        <= 1'b0;
            rf_rr1       <= '0;
            rf_rr2       <= '0;
            rf_wr        <= '0;
            rf_wd        <= '0;
            conflict_cnt <= '0;
        end else begin
            gnt_a    <= arb && !pick_b;
            gnt_b    <= arb && pick_b;
            rvalid_a <= state == ACCESS && !win;
            rvalid_b <= state == ACCESS && win;
            // writes to x0 are dropped here so the register file never sees them
            rf_we    <= arb && (pick_b ? we_b && |wr_b : we_a && |wr_a);
            if (state == ACCESS && !win) begin
                rdata1_a <= rd1_m;
                rdata2_a <= rd2_m;
            end
            if (state == ACCESS && win) begin
                rdata1_b <= rd1_m;
                rdata2_b <= rd2_m;
            end
            if (arb) begin
                rf_rr1 <= pick_b ? rr1_b : rr1_a;
                rf_rr2 <= pick_b ? rr2_b : rr2_a;
                rf_wr  <= pick_b ? wr_b : wr_a;
                rf_wd  <= pick_b ? wd_b : wd_a;
                win    <= pick_b;
                prio   <= !pick_b;
                if (both && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed checks of grant order, latency, x0 guard, reset and counter saturation
module tb_regfile_port_arbiter;
    logic clk = 1'b0, rst = 1'b0, force_ff = 1'b0;
    logic req_a = 0, we_a = 0, req_b = 0, we_b = 0;
    logic [4:0] rr1_a = 0, rr2_a = 0, wr_a = 0, rr1_b = 0, rr2_b = 0, wr_b = 0;
    logic [31:0] wd_a = 0, wd_b = 0;
    logic gnt_a, gnt_b, rvalid_a, rvalid_b, rf_we, busy;
    logic [31:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b, rf_wd, rf_rd1, rf_rd2;
    logic [4:0] rf_rr1, rf_rr2, rf_wr;
    logic [7:0] conflict_cnt;
    logic s_gnt_a, s_gnt_b, s_rvalid_a, s_rvalid_b, s_rf_we, s_busy;
    logic [31:0] s_rdata1_a, s_rdata2_a, s_rdata1_b, s_rdata2_b, s_rf_wd;
    logic [4:0] s_rf_rr1, s_rf_rr2, s_rf_wr;
    logic [1:0] sat_cnt;
    logic [31:0] regs [32];
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    regfile_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .rr1_a(rr1_a), .rr2_a(rr2_a), .wr_a(wr_a), .wd_a(wd_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata1_a(rdata1_a), .rdata2_a(rdata2_a),
        .req_b(req_b), .we_b(we_b), .rr1_b(rr1_b), .rr2_b(rr2_b), .wr_b(wr_b), .wd_b(wd_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata1_b(rdata1_b), .rdata2_b(rdata2_b),
        .rf_we(rf_we), .rf_rr1(rf_rr1), .rf_rr2(rf_rr2), .rf_wr(rf_wr), .rf_wd(rf_wd),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .busy(busy), .conflict_cnt(conflict_cnt)
    );

    // second instance with a 2-bit counter shares the inputs to exercise saturation
    regfile_port_arbiter #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .rr1_a(rr1_a), .rr2_a(rr2_a), .wr_a(wr_a), .wd_a(wd_a),
        .gnt_a(s_gnt_a), .rvalid_a(s_rvalid_a), .rdata1_a(s_rdata1_a), .rdata2_a(s_rdata2_a),
        .req_b(req_b), .we_b(we_b), .rr1_b(rr1_b), .rr2_b(rr2_b), .wr_b(wr_b), .wd_b(wd_b),
        .gnt_b(s_gnt_b), .rvalid_b(s_rvalid_b), .rdata1_b(s_rdata1_b), .rdata2_b(s_rdata2_b),
        .rf_we(s_rf_we), .rf_rr1(s_rf_rr1), .rf_rr2(s_rf_rr2), .rf_wr(s_rf_wr), .rf_wd(s_rf_wd),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .busy(s_busy), .conflict_cnt(sat_cnt)
    );

    assign rf_rd1 = force_ff ? 32'hFFFF_FFFF : regs[rf_rr1];
    assign rf_rd2 = regs[rf_rr2];
    always @(posedge clk) if (rf_we) regs[rf_wr] <= rf_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[3] = 32'h11;
        regs[4] = 32'h22;
        regs[7] = 32'h77;
        step(2);
        chk("rst_gnt_a", {31'b0, gnt_a}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_cnt", {24'b0, conflict_cnt}, 0);
        chk("rst_rdata1_a", rdata1_a, 0);
        // contention from reset: A,B,A,B,A
        req_a = 1; req_b = 1;
        rst = 1;
        step();
        chk("c1_gnt_a", {31'b0, gnt_a}, 1);
        chk("c1_gnt_b", {31'b0, gnt_b}, 0);
        chk("c1_cnt", {24'b0, conflict_cnt}, 1);
        step();
        chk("c1_rvalid_a", {31'b0, rvalid_a}, 1);
        chk("c1_gnt_off", {31'b0, gnt_a}, 0);
        step();
        chk("c2_gnt_b", {31'b0, gnt_b}, 1);
        chk("c2_gnt_a", {31'b0, gnt_a}, 0);
        chk("c2_cnt", {24'b0, conflict_cnt}, 2);
        step(2);
        chk("c3_gnt_a", {31'b0, gnt_a}, 1);
        chk("c3_cnt", {24'b0, conflict_cnt}, 3);
        chk("c3_sat", {30'b0, sat_cnt}, 3);
        step(2);
        chk("c4_gnt_b", {31'b0, gnt_b}, 1);
        chk("c4_cnt", {24'b0, conflict_cnt}, 4);
        step(2);
        chk("c5_gnt_a", {31'b0, gnt_a}, 1);
        chk("c5_sat_hold", {30'b0, sat_cnt}, 3);
        req_a = 0; req_b = 0;
        step(2);
        chk("c_idle", {31'b0, busy}, 0);
        // single read by A
        req_a = 1; rr1_a = 3; rr2_a = 4; we_a = 0;
        step();
        chk("rd_gnt_a", {31'b0, gnt_a}, 1);
        chk("rd_rf_we", {31'b0, rf_we}, 0);
        chk("rd_busy", {31'b0, busy}, 1);
        req_a = 0;
        step();
        chk("rd_rvalid_a", {31'b0, rvalid_a}, 1);
        chk("rd_rdata1_a", rdata1_a, 32'h11);
        chk("rd_rdata2_a", rdata2_a, 32'h22);
        chk("rd_rf_we_resp", {31'b0, rf_we}, 0);
        step();
        chk("rd_rvalid_off", {31'b0, rvalid_a}, 0);
        // B writes x7 and reads it in the same transaction
        req_b = 1; we_b = 1; wr_b = 7; wd_b = 32'hDEADBEEF; rr1_b = 7; rr2_b = 0;
        step();
        chk("wr_gnt_b", {31'b0, gnt_b}, 1);
        chk("wr_rf_we", {31'b0, rf_we}, 1);
        chk("wr_rf_wr", {27'b0, rf_wr}, 7);
        req_b = 0; we_b = 0;
        step();
        chk("wr_rvalid_b", {31'b0, rvalid_b}, 1);
        chk("wr_old_x7", rdata1_b, 32'h77);
        chk("wr_rd2_x0", rdata2_b, 0);
        chk("wr_a_hold", rdata1_a, 32'h11);
        chk("wr_rf_we_off", {31'b0, rf_we}, 0);
        step();
        req_b = 1;
        step();
        chk("rb_gnt_b", {31'b0, gnt_b}, 1);
        req_b = 0;
        step();
        chk("rb_new_x7", rdata1_b, 32'hDEADBEEF);
        step();
        // x0 guard
        req_a = 1; we_a = 1; wr_a = 0; wd_a = 32'h5; rr1_a = 0; rr2_a = 3; force_ff = 1;
        step();
        chk("x0_gnt_a", {31'b0, gnt_a}, 1);
        chk("x0_rf_we", {31'b0, rf_we}, 0);
        req_a = 0; we_a = 0;
        step();
        chk("x0_rvalid_a", {31'b0, rvalid_a}, 1);
        chk("x0_rdata1_a", rdata1_a, 0);
        chk("x0_rdata2_a", rdata2_a, 32'h11);
        force_ff = 0;
        step();
        // reset in the ACCESS cycle of a write
        req_a = 1; we_a = 1; wr_a = 5; wd_a = 32'hAB; rr1_a = 3;
        step();
        chk("mr_rf_we", {31'b0, rf_we}, 1);
        req_a = 0; we_a = 0; rst = 0;
        step();
        chk("mr_rvalid_a", {31'b0, rvalid_a}, 0);
        chk("mr_gnt_a", {31'b0, gnt_a}, 0);
        chk("mr_rf_we_off", {31'b0, rf_we}, 0);
        chk("mr_rf_wr", {27'b0, rf_wr}, 0);
        chk("mr_busy", {31'b0, busy}, 0);
        chk("mr_cnt", {24'b0, conflict_cnt}, 0);
        chk("mr_rdata1_b", rdata1_b, 0);
        rst = 1; req_a = 1; req_b = 1;
        step();
        chk("mr_prio_a", {31'b0, gnt_a}, 1);
        chk("mr_prio_b", {31'b0, gnt_b}, 0);
        req_a = 0; req_b = 0;
        step(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
